// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared types and helpers for the round-robin mux scheduler.
//   N_REQ   - number of requester lanes
//   SEL_W   - width of a lane index / mux select
//   state_t - scheduler FSM states
//   pick_t  - arbitration result (found flag + winning lane index)
//   rr_pick - round-robin search starting at ptr
package mux_sched_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Search order is ptr, ptr+1, ptr+2, ptr+3; the index wraps naturally at SEL_W bits.
   function automatic pick_t rr_pick(input logic [SEL_W-1:0] ptr,
                                     input logic [N_REQ-1:0] req);
      pick_t            p;
      logic [SEL_W-1:0] cand;
      p.found = 1'b0;
      p.idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = ptr + SEL_W'(k);
         if (!p.found && req[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4.sv
// mux4: parameterised-width 4:1 combinational data mux.
//   in_data  - four lanes packed, lane i at [i*DW +: DW]
//   sel      - lane index
//   out_data - selected lane
module mux4
   import mux_sched_pkg::*;
#(
   parameter int unsigned DW = 1
) (
   input  logic [N_REQ*DW-1:0] in_data,
   input  logic [SEL_W-1:0]    sel,
   output logic [DW-1:0]       out_data
);

   always_comb begin
      out_data = '0;
      case (sel)
         2'd0:    out_data = in_data[0*DW +: DW];
         2'd1:    out_data = in_data[1*DW +: DW];
         2'd2:    out_data = in_data[2*DW +: DW];
         default: out_data = in_data[3*DW +: DW];
      endcase
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin scheduler sharing one 4:1 data mux among
// four requesters, holding each grant for a burst of valid/ready beats.
//   clk, rst_n - clock (rising edge) and async active-low reset
//   req, last  - per-lane request and final-beat flag
//   in_data    - four lanes packed, lane i at [i*DW +: DW]
//   out_ready  - downstream ready
//   gnt, Sel   - registered one-hot grant and owner index
//   out_valid  - owner has a beat available
//   out_data   - owner's lane data through the mux
//   busy       - a grant is active
module mux_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int unsigned DW        = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    last,
   input  logic [N_REQ*DW-1:0] in_data,
   input  logic                out_ready,
   output logic [N_REQ-1:0]    gnt,
   output logic [SEL_W-1:0]    Sel,
   output logic                out_valid,
   output logic [DW-1:0]       out_data,
   output logic                busy
);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [3:0]       beat_cnt_q, beat_cnt_d;

   logic  xfer;
   logic  rel;
   pick_t pick;

   assign out_valid = (state_q == GRANT) && req[sel_q];
   assign xfer      = out_valid && out_ready;
   assign rel       = (state_q == GRANT) &&
                      (!req[sel_q] ||
                       (xfer && (last[sel_q] || (beat_cnt_q == 4'(MAX_BURST - 1)))));

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      beat_cnt_d = beat_cnt_q;
      pick       = rr_pick(ptr_q, req);

      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick.found) begin
               gnt_d[pick.idx] = 1'b1;
               sel_d           = pick.idx;
               beat_cnt_d      = '0;
               state_d         = GRANT;
            end
         end
         default: begin
            if (rel) begin
               // Re-arbitrate over the rotated order so hand-over costs no bubble.
               ptr_d      = sel_q + 2'd1;
               pick       = rr_pick(ptr_d, req);
               gnt_d      = '0;
               beat_cnt_d = '0;
               if (pick.found) begin
                  gnt_d[pick.idx] = 1'b1;
                  sel_d           = pick.idx;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         sel_q      <= '0;
         ptr_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign gnt  = gnt_q;
   assign Sel  = sel_q;
   assign busy = (state_q == GRANT);

   mux4 #(.DW(DW)) u_mux4 (
      .in_data  (in_data),
      .sel      (sel_q),
      .out_data (out_data)
   );

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: directed self-checking bench for mux_rr_scheduler
// (DW=1, MAX_BURST=4). Inputs change 1 time unit after a rising edge;
// outputs are checked before the next edge.
module tb_mux_rr_scheduler;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [3:0] in_data;
   logic       out_ready;
   logic [3:0] gnt;
   logic [1:0] Sel;
   logic       out_valid;
   logic [0:0] out_data;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   mux_rr_scheduler #(.DW(1), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .in_data   (in_data),
      .out_ready (out_ready),
      .gnt       (gnt),
      .Sel       (Sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 4'b0100;
      last      = 4'b0000;
      in_data   = 4'b0000;
      out_ready = 1'b1;

      // 1: reset with lane 2 requesting
      #12;
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_sel", Sel, 2'd0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("t1_gnt", gnt, 4'b0100);
      chk("t1_sel", Sel, 2'd2);
      chk("t1_busy", busy, 1'b1);
      chk("t1_valid", out_valid, 1'b1);
      req = 4'b0000;
      #1;
      chk("t1_valid_drop", out_valid, 1'b0);
      tick();
      chk("t1_idle_gnt", gnt, 4'b0000);
      chk("t1_idle_busy", busy, 1'b0);

      // 2: lone lane 1, three beats 1,0,1 with last on the third
      req     = 4'b0010;
      in_data = 4'b0010;
      tick();
      chk("t2_gnt", gnt, 4'b0010);
      chk("t2_sel", Sel, 2'd1);
      in_data = 4'b0010;
      #1;
      chk("t2_d0", out_data, 1'b1);
      tick();
      chk("t2_gnt_b1", gnt, 4'b0010);
      in_data = 4'b1101;
      #1;
      chk("t2_d1", out_data, 1'b0);
      tick();
      chk("t2_gnt_b2", gnt, 4'b0010);
      in_data = 4'b0010;
      last    = 4'b0010;
      #1;
      chk("t2_d2", out_data, 1'b1);
      chk("t2_valid", out_valid, 1'b1);
      tick();
      chk("t2_regrant", gnt, 4'b0010);
      req  = 4'b0000;
      last = 4'b0000;
      tick();
      chk("t2_idle", gnt, 4'b0000);

      // 3: all lanes, single-beat bursts rotate with no bubble
      pulse_reset();
      req  = 4'b1111;
      last = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] exp_g;
         exp_g = 4'b0001 << (i % 4);
         tick();
         chk($sformatf("t3_gnt%0d", i), gnt, exp_g);
         chk($sformatf("t3_busy%0d", i), busy, 1'b1);
      end
      req  = 4'b0000;
      last = 4'b0000;
      tick();
      chk("t3_idle", gnt, 4'b0000);

      // 4: forced rotation after MAX_BURST beats
      pulse_reset();
      req = 4'b0011;
      for (int i = 0; i < 9; i++) begin
         logic [3:0] exp_g;
         exp_g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
         tick();
         chk($sformatf("t4_gnt%0d", i), gnt, exp_g);
      end
      req = 4'b0000;
      tick();
      chk("t4_idle", gnt, 4'b0000);

      // 5: backpressure freezes lane 2; lane 0 waits as a non-owner
      pulse_reset();
      req = 4'b0100;
      tick();
      chk("t5_gnt", gnt, 4'b0100);
      req       = 4'b0101;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_stall_gnt%0d", i), gnt, 4'b0100);
         chk($sformatf("t5_stall_sel%0d", i), Sel, 2'd2);
         chk($sformatf("t5_stall_valid%0d", i), out_valid, 1'b1);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_xfer_gnt%0d", i), gnt, 4'b0100);
      end
      req = 4'b0000;
      #1;
      chk("t5_valid_drop", out_valid, 1'b0);
      tick();
      chk("t5_drop_gnt", gnt, 4'b0000);
      req = 4'b1001;
      tick();
      chk("t5_ptr3_gnt", gnt, 4'b1000);
      chk("t5_ptr3_sel", Sel, 2'd3);

      // 6: async reset in the middle of a lane 3 burst
      req = 4'b0000;
      tick();
      pulse_reset();
      req = 4'b1000;
      tick();
      chk("t6_gnt", gnt, 4'b1000);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt", gnt, 4'b0000);
      chk("t6_rst_sel", Sel, 2'd0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      req   = 4'b1001;
      tick();
      chk("t6_after_gnt", gnt, 4'b0001);
      chk("t6_after_sel", Sel, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
